// File: rtl/branch_target_writer.sv
// Branch-target table writer.
// Accepts a stream of TW-bit PC targets over a valid/ready handshake and writes them
// into a BANKS x 2**AW table, one bank per load. A combinational read port exposes
// table[ProgState][addr] to fetch at all times.
// Optional feature: define TBL_CLEAR_EN to zero the selected bank (one entry per
// cycle) before each load; when undefined, unloaded entries keep their old contents.
module branch_target_writer #(
  parameter int TW    = 10,
  parameter int AW    = 3,
  parameter int BANKS = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    Bank,
  input  logic [AW:0]   Len,
  input  logic          InValid,
  input  logic [TW-1:0] InData,
  output logic          InReady,
  output logic          Busy,
  output logic          Done,
  output logic          Err,
  input  logic [1:0]    ProgState,
  input  logic [AW-1:0] addr,
  output logic [TW-1:0] Target
);

  localparam int DEPTH = 2**AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
`ifdef TBL_CLEAR_EN
  localparam logic [1:0] S_CLEAR = 2'd1;
`endif
  localparam logic [1:0] S_LOAD  = 2'd2;

  localparam logic [1:0]    BANK_LIM = 2'(BANKS);
  localparam logic [AW:0]   FULL_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LEN_ZERO = {(AW+1){1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

  // Table storage
  logic [TW-1:0] mem [BANKS][DEPTH];

  // Control state
  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [1:0]    bank_q;
  logic [AW:0]   len_q;
  logic [AW:0]   len_eff;
  logic [AW-1:0] ptr;
  logic [AW:0]   cnt;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  // Decoded strobes
  logic          start_ok;
  logic          start_bad;
  logic          last_xfer;
  logic          xfer;
  logic          clr_we;
  logic [1:0]    rd_bank;

  assign xfer = InValid & ready_q;

`ifdef TBL_CLEAR_EN
  assign clr_we = (state == S_CLEAR);
`else
  assign clr_we = 1'b0;
`endif

  // Normalise the requested length: 0 (and anything past a full bank) means a full bank
  always_comb begin
    len_eff = Len;
    if ((Len == LEN_ZERO) || (Len > FULL_LEN)) begin
      len_eff = FULL_LEN;
    end else begin
      len_eff = Len;
    end
  end

  // Next-state decode and one-cycle event strobes
  always_comb begin
    next_state = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    last_xfer  = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (Bank < BANK_LIM) begin
            start_ok = 1'b1;
`ifdef TBL_CLEAR_EN
            next_state = S_CLEAR;
`else
            next_state = S_LOAD;
`endif
          end else begin
            start_bad  = 1'b1;
            next_state = S_IDLE;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
`ifdef TBL_CLEAR_EN
      S_CLEAR: begin
        if (ptr == PTR_LAST) begin
          next_state = S_LOAD;
        end else begin
          next_state = S_CLEAR;
        end
      end
`endif
      S_LOAD: begin
        // cnt+1 == len avoids an underflowing len-1 and never wraps at a full bank
        if (xfer && ((cnt + LEN_ONE) == len_q)) begin
          last_xfer  = 1'b1;
          next_state = S_IDLE;
        end else begin
          next_state = S_LOAD;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Control registers: state, load parameters, pointer/count and registered status outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      bank_q  <= 2'd0;
      len_q   <= LEN_ZERO;
      ptr     <= PTR_ZERO;
      cnt     <= LEN_ZERO;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == S_LOAD);
      busy_q  <= (next_state != S_IDLE);
      done_q  <= last_xfer;
      err_q   <= start_bad;
      if (start_ok) begin
        bank_q <= Bank;
        len_q  <= len_eff;
        ptr    <= PTR_ZERO;
        cnt    <= LEN_ZERO;
      end else if (clr_we) begin
        // pointer wraps back to 0 after the last cleared entry, ready for LOAD
        ptr <= ptr + PTR_ONE;
      end else if (xfer) begin
        ptr <= ptr + PTR_ONE;
        cnt <= cnt + LEN_ONE;
      end
    end
  end

  // Table writes: zero on reset, clear sweep, or one accepted target per handshake
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem[b][e] <= {TW{1'b0}};
        end
      end
    end else if (clr_we) begin
      mem[bank_q][ptr] <= {TW{1'b0}};
    end else if (xfer) begin
      mem[bank_q][ptr] <= InData;
    end
  end

  // Read bank select: out-of-range ProgState falls back to bank 0
  always_comb begin
    rd_bank = 2'd0;
    if (ProgState < BANK_LIM) begin
      rd_bank = ProgState;
    end else begin
      rd_bank = 2'd0;
    end
  end

  assign Target  = mem[rd_bank][addr];
  assign InReady = ready_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;

endmodule
